// File: rtl/dot_product_pkg.sv
// Shared types and constants for the dot-product feeder: FSM states,
// host write-select encodings and the result-width rule.
package dot_product_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WAIT_RESULT,
        DONE
    } feeder_state_e;

    localparam logic WR_SEL_A = 1'b0;
    localparam logic WR_SEL_B = 1'b1;

    // Full-precision sum of VECTOR_WIDTH products of two DATA_WIDTH operands.
    function automatic int calcResultWidth(input int dataWidth, input int vectorWidth);
        return 2 * dataWidth + $clog2(vectorWidth);
    endfunction

endpackage

// File: rtl/vector_ram.sv
// Single-write-port vector memory with a registered, read-first read port.
// Only the read-data register is reset; the storage array keeps its contents.
module vector_ram
    import dot_product_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wrEn_i,
    input  logic [ADDR_WIDTH-1:0] wrAddr_i,
    input  logic [DATA_WIDTH-1:0] wrData_i,
    input  logic                  rdEn_i,
    input  logic [ADDR_WIDTH-1:0] rdAddr_i,
    output logic [DATA_WIDTH-1:0] rdData_o
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk_i) begin
        if (wrEn_i) begin
            mem[wrAddr_i] <= wrData_i;
        end
    end

    // Non-blocking read sees the pre-write value on a same-address collision.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdData_o <= '0;
        end else if (rdEn_i) begin
            rdData_o <= mem[rdAddr_i];
        end
    end

endmodule

// File: rtl/dot_product_feeder.sv
// Streams element pairs of vectors A and B to the dotProduct core with a
// programmable idle gap, then captures the core's result.
module dot_product_feeder
    import dot_product_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int VECTOR_WIDTH = 4,
    parameter int ADDR_WIDTH   = 5,
    parameter int ISSUE_GAP    = 1,
    parameter int RESULT_WIDTH = calcResultWidth(DATA_WIDTH, VECTOR_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic                    wr_sel,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    output logic [DATA_WIDTH-1:0]   data_from_mem1,
    output logic [DATA_WIDTH-1:0]   data_from_mem2,
    output logic                    data_valid,
    input  logic [RESULT_WIDTH-1:0] dot_product_result,
    input  logic                    processing_done,
    output logic [RESULT_WIDTH-1:0] result_q,
    output logic                    busy,
    output logic                    done
);

    localparam int CNT_W = (VECTOR_WIDTH > 1) ? $clog2(VECTOR_WIDTH) : 1;
    localparam int GAP_W = (ISSUE_GAP > 0) ? $clog2(ISSUE_GAP + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VECTOR_WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(ISSUE_GAP);

    feeder_state_e         state_q;
    logic [ADDR_WIDTH-1:0] rdAddr_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [GAP_W-1:0]      gap_q;
    logic                  readFire;
    logic                  wrEnA;
    logic                  wrEnB;

    assign readFire = (state_q == READ) && (gap_q == '0);
    assign wrEnA    = wr_en && (wr_sel == WR_SEL_A);
    assign wrEnB    = wr_en && (wr_sel == WR_SEL_B);

    vector_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) memA (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .wrEn_i  (wrEnA),
        .wrAddr_i(wr_addr),
        .wrData_i(wr_data),
        .rdEn_i  (readFire),
        .rdAddr_i(rdAddr_q),
        .rdData_o(data_from_mem1)
    );

    vector_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) memB (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .wrEn_i  (wrEnB),
        .wrAddr_i(wr_addr),
        .wrData_i(wr_data),
        .rdEn_i  (readFire),
        .rdAddr_i(rdAddr_q),
        .rdData_o(data_from_mem2)
    );

    // data_valid is set on the same edge the RAM read registers load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rdAddr_q   <= '0;
            cnt_q      <= '0;
            gap_q      <= '0;
            data_valid <= 1'b0;
            result_q   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            done       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= READ;
                        rdAddr_q <= base_addr;
                        cnt_q    <= '0;
                        gap_q    <= '0;
                        busy     <= 1'b1;
                    end
                end
                READ: begin
                    if (gap_q == '0) begin
                        data_valid <= 1'b1;
                        rdAddr_q   <= rdAddr_q + ADDR_WIDTH'(1);
                        cnt_q      <= cnt_q + CNT_W'(1);
                        gap_q      <= GAP_RELOAD;
                        if (cnt_q == LAST_CNT) begin
                            state_q <= WAIT_RESULT;
                        end
                    end else begin
                        gap_q <= gap_q - GAP_W'(1);
                    end
                end
                WAIT_RESULT: begin
                    if (processing_done) begin
                        result_q <= dot_product_result;
                        done     <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
